// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path.
// Holds the opcode values, FSM state codes and the ALUOp, PCSrc and ALUSrcB
// select codes. The ALU decoder and the testbench import the same constants.
package cpu_ctrl_pkg;

  localparam int OPCODE_W_DEF = 6;
  localparam int STATE_W_DEF  = 4;

  // Opcodes, Instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Controller states. Codes 12-15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  // ALUOp codes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PCSrc codes
  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALUSrcB codes
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J)  || (op == OP_BEQ) ||
           (op == OP_ADDI)  || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle CPU.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath mux selects and write enables.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   Opcode            instruction opcode (valid from DECODE onward)
//   Zero              ALU zero flag, gates PCEn in BRANCH
//   mem_ready         memory access completes this cycle
//   IorD, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
//   MemWrite, RegWrite, RegDst, MemtoReg   datapath controls
//   illegal_op        one-cycle pulse on an unrecognised opcode in DECODE
//   state_dbg         current state code
module multicycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Zero,
  input  logic                mem_ready,
  output logic                IorD,
  output logic                IRWrite,
  output logic                PCEn,
  output logic [1:0]          PCSrc,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic                MemWrite,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                illegal_op,
  output logic [STATE_W-1:0]  state_dbg
);

  state_e     state_q, state_d;
  logic [5:0] op;
  logic       pc_write;
  logic       branch;

  assign op        = 6'(Opcode);
  assign state_dbg = STATE_W'(state_q);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        // Opcode cannot change here (IRWrite is low), but an unexpected
        // value still falls back to FETCH rather than guessing.
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode. Reset overrides the state so a write in progress is
  // cut off in the same cycle rst_n goes low, not one cycle later.
  always_comb begin
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    PCSrc      = PCSRC_ALURES;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REGB;
    ALUOp      = ALUOP_ADD;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    illegal_op = 1'b0;
    PCEn       = 1'b0;

    if (!rst_n) begin
      ALUSrcB = SRCB_FOUR;
    end else begin
      case (state_q)
        S_FETCH: begin
          ALUSrcB  = SRCB_FOUR;
          IRWrite  = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB    = SRCB_IMM_SH2;
          illegal_op = !is_known_op(op);
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMRD:  IorD = 1'b1;
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_SUB;
          PCSrc   = PCSRC_ALUOUT;
          branch  = 1'b1;
        end
        S_ADDIEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_ADDIWB: RegWrite = 1'b1;
        S_JUMP: begin
          PCSrc    = PCSRC_JUMP;
          pc_write = 1'b1;
        end
        default: ;
      endcase
      PCEn = pc_write | (branch & Zero);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Opcode;
  logic       Zero;
  logic       mem_ready;
  logic       IorD, IRWrite, PCEn, ALUSrcA, MemWrite, RegWrite, RegDst, MemtoReg, illegal_op;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl_fsm #(.OPCODE_W(6), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .IorD(IorD), .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Control word: {IorD, IRWrite, PCEn, PCSrc[1:0], ALUSrcA, ALUSrcB[1:0],
  //                ALUOp[1:0], MemWrite, RegWrite, RegDst, MemtoReg, illegal_op}
  //                          IorD IRW PCEn PCSrc SrcA SrcB  ALUOp MW RW RD M2R ILL
  localparam logic [14:0] E_RST    = 15'b0_0_0_00_0_01_00_0_0_0_0_0;
  localparam logic [14:0] E_FRDY   = 15'b0_1_1_00_0_01_00_0_0_0_0_0;
  localparam logic [14:0] E_FWAIT  = 15'b0_0_0_00_0_01_00_0_0_0_0_0;
  localparam logic [14:0] E_DEC    = 15'b0_0_0_00_0_11_00_0_0_0_0_0;
  localparam logic [14:0] E_ILL    = 15'b0_0_0_00_0_11_00_0_0_0_0_1;
  localparam logic [14:0] E_MADR   = 15'b0_0_0_00_1_10_00_0_0_0_0_0;
  localparam logic [14:0] E_MRD    = 15'b1_0_0_00_0_00_00_0_0_0_0_0;
  localparam logic [14:0] E_MWB    = 15'b0_0_0_00_0_00_00_0_1_0_1_0;
  localparam logic [14:0] E_MWR    = 15'b1_0_0_00_0_00_00_1_0_0_0_0;
  localparam logic [14:0] E_EXEC   = 15'b0_0_0_00_1_00_10_0_0_0_0_0;
  localparam logic [14:0] E_ALUWB  = 15'b0_0_0_00_0_00_00_0_1_1_0_0;
  localparam logic [14:0] E_BR_Z   = 15'b0_0_1_01_1_00_01_0_0_0_0_0;
  localparam logic [14:0] E_BR_NZ  = 15'b0_0_0_01_1_00_01_0_0_0_0_0;
  localparam logic [14:0] E_AEXEC  = 15'b0_0_0_00_1_10_00_0_0_0_0_0;
  localparam logic [14:0] E_AWB    = 15'b0_0_0_00_0_00_00_0_1_0_0_0;
  localparam logic [14:0] E_JUMP   = 15'b0_0_1_10_0_00_00_0_0_0_0_0;

  typedef struct packed {
    logic        rst_n;
    logic [5:0]  op;
    logic        zero;
    logic        mr;
    logic [3:0]  st;
    logic [14:0] ctl;
  } vec_t;

  vec_t tv[64];
  int   nvec = 0;

  function automatic logic [14:0] ctl_now();
    return {IorD, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
            MemWrite, RegWrite, RegDst, MemtoReg, illegal_op};
  endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic z, input logic mr,
                     input logic [3:0] st, input logic [14:0] ctl);
    tv[nvec] = '{rst_n: r, op: op, zero: z, mr: mr, st: st, ctl: ctl};
    nvec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic z, input logic mr);
    @(negedge clk);
    rst_n = r; Opcode = op; Zero = z; mem_ready = mr;
    #1;
  endtask

  int ill_cnt;
  int we_cnt;

  initial begin
    rst_n = 1'b0; Opcode = OP_LW; Zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);

    // Reset held two cycles, then LW with no waits: 0,1,2,3,4,0
    add(0, OP_LW, 0, 1, 4'd0, E_RST);
    add(0, OP_LW, 0, 1, 4'd0, E_RST);
    add(1, OP_LW, 0, 1, 4'd0, E_FRDY);
    add(1, OP_LW, 1, 1, 4'd1, E_DEC);
    add(1, OP_LW, 1, 1, 4'd2, E_MADR);
    add(1, OP_LW, 1, 1, 4'd3, E_MRD);
    add(1, OP_LW, 1, 1, 4'd4, E_MWB);
    // SW with three wait cycles in MEMWR
    add(1, OP_SW, 0, 1, 4'd0, E_FRDY);
    add(1, OP_SW, 0, 1, 4'd1, E_DEC);
    add(1, OP_SW, 0, 1, 4'd2, E_MADR);
    add(1, OP_SW, 0, 0, 4'd5, E_MWR);
    add(1, OP_SW, 0, 0, 4'd5, E_MWR);
    add(1, OP_SW, 0, 0, 4'd5, E_MWR);
    add(1, OP_SW, 0, 1, 4'd5, E_MWR);
    // BEQ taken, then not taken
    add(1, OP_BEQ, 1, 1, 4'd0, E_FRDY);
    add(1, OP_BEQ, 1, 1, 4'd1, E_DEC);
    add(1, OP_BEQ, 1, 1, 4'd8, E_BR_Z);
    add(1, OP_BEQ, 0, 1, 4'd0, E_FRDY);
    add(1, OP_BEQ, 0, 1, 4'd1, E_DEC);
    add(1, OP_BEQ, 0, 1, 4'd8, E_BR_NZ);
    // Illegal opcode
    add(1, 6'b111111, 1, 1, 4'd0, E_FRDY);
    add(1, 6'b111111, 1, 1, 4'd1, E_ILL);
    // RTYPE with one fetch wait
    add(1, OP_RTYPE, 1, 0, 4'd0, E_FWAIT);
    add(1, OP_RTYPE, 1, 1, 4'd0, E_FRDY);
    add(1, OP_RTYPE, 1, 1, 4'd1, E_DEC);
    add(1, OP_RTYPE, 1, 1, 4'd6, E_EXEC);
    add(1, OP_RTYPE, 1, 1, 4'd7, E_ALUWB);
    // ADDI
    add(1, OP_ADDI, 1, 1, 4'd0, E_FRDY);
    add(1, OP_ADDI, 1, 1, 4'd1, E_DEC);
    add(1, OP_ADDI, 1, 1, 4'd9, E_AEXEC);
    add(1, OP_ADDI, 1, 1, 4'd10, E_AWB);
    // J
    add(1, OP_J, 0, 1, 4'd0, E_FRDY);
    add(1, OP_J, 0, 1, 4'd1, E_DEC);
    add(1, OP_J, 0, 1, 4'd11, E_JUMP);
    // LW with one read wait
    add(1, OP_LW, 0, 1, 4'd0, E_FRDY);
    add(1, OP_LW, 0, 1, 4'd1, E_DEC);
    add(1, OP_LW, 0, 1, 4'd2, E_MADR);
    add(1, OP_LW, 0, 0, 4'd3, E_MRD);
    add(1, OP_LW, 0, 1, 4'd3, E_MRD);
    add(1, OP_LW, 0, 1, 4'd4, E_MWB);
    // RTYPE, reset asserted during ALUWB
    add(1, OP_RTYPE, 0, 1, 4'd0, E_FRDY);
    add(1, OP_RTYPE, 0, 1, 4'd1, E_DEC);
    add(1, OP_RTYPE, 0, 1, 4'd6, E_EXEC);
    add(0, OP_RTYPE, 0, 1, 4'd7, E_RST);
    add(1, OP_RTYPE, 0, 0, 4'd0, E_FWAIT);

    for (int i = 0; i < nvec; i++) begin
      drive(tv[i].rst_n, tv[i].op, tv[i].zero, tv[i].mr);
      chk($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(tv[i].st));
      chk($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(tv[i].ctl));
    end

    // Reset during a stalled store: the write strobe must drop immediately.
    drive(1, OP_SW, 0, 1);
    chk("sw_rst_fetch", 32'(state_dbg), 32'd0);
    drive(1, OP_SW, 0, 1);
    drive(1, OP_SW, 0, 1);
    drive(1, OP_SW, 0, 0);
    chk("sw_rst_in_memwr", 32'(state_dbg), 32'd5);
    chk("sw_rst_memwrite_before", 32'(MemWrite), 32'd1);
    drive(0, OP_SW, 0, 0);
    chk("sw_rst_memwrite_during", 32'(MemWrite), 32'd0);
    chk("sw_rst_iord_during", 32'(IorD), 32'd0);
    drive(1, OP_SW, 0, 0);
    chk("sw_rst_state_after", 32'(state_dbg), 32'd0);
    chk("sw_rst_memwrite_after", 32'(MemWrite), 32'd0);

    // Illegal opcode: exactly one pulse over FETCH, DECODE, FETCH; no writes.
    ill_cnt = 0;
    we_cnt  = 0;
    for (int c = 0; c < 3; c++) begin
      drive(1, 6'b110000, 1, 1);
      chk($sformatf("ill_seq_state%0d", c), 32'(state_dbg), (c == 1) ? 32'd1 : 32'd0);
      if (illegal_op) ill_cnt++;
      if (MemWrite || RegWrite) we_cnt++;
    end
    chk("ill_pulse_count", 32'(ill_cnt), 32'd1);
    chk("ill_write_count", 32'(we_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control state machine of the multicycle CPU.
- Sits directly downstream of the instruction register and consumes its 6-bit Opcode.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and drives all datapath mux selects and write enables.
- Funct-level ALU control is produced by the separate ALU decoder from ALUOp; it is not part of this block.

Parameters:
- OPCODE_W, 6, opcode field width (Instr[31:26])
- STATE_W, 4, state register width

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- Opcode  in  6  opcode from the instruction register, valid from DECODE onward
- Zero  in  1  ALU zero flag
- mem_ready  in  1  unified memory handshake: 1 = current access completes this cycle
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  instruction register load enable
- PCEn  out  1  PC load enable = PCWrite | (Branch & Zero)
- PCSrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- ALUSrcA  out  1  0 = PC, 1 = regA
- ALUSrcB  out  2  00 = regB, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded
- MemWrite  out  1  data memory write strobe
- RegWrite  out  1  register file write enable
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = Data register
- illegal_op  out  1  one-cycle pulse on an unrecognised opcode
- state_dbg  out  4  current state encoding, for debug/verification

Behaviour:
- Moore FSM: state is registered; outputs decode from state only, except the mem_ready qualification noted below and PCEn's use of Zero.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
- Codes 12-15 are illegal; if entered, next state is FETCH.
- Opcodes: LW=100011, SW=101011, RTYPE=000000, BEQ=000100, ADDI=001000, J=000010.
- Reset: rst_n low at a rising edge sets state to FETCH.
  - While rst_n is low, IRWrite, PCEn, MemWrite, RegWrite and illegal_op are forced to 0.
  - All other outputs take their FETCH values.
  - A reset mid-instruction abandons it; no partial write is issued after the reset edge.
- FETCH:
  - IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite are asserted only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Opcode:
  - LW or SW -> MEMADR
  - RTYPE -> EXECUTE
  - BEQ -> BRANCH
  - ADDI -> ADDIEXEC
  - J -> JUMP
  - any other -> FETCH, with illegal_op=1 for this cycle only
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEMRD, SW -> MEMWR.
- MEMRD: IorD=1. Waits on mem_ready=0; goes to MEMWB when mem_ready=1.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state FETCH.
- MEMWR: IorD=1, MemWrite=1 for every cycle in the state. Leaves to FETCH when mem_ready=1.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, so PCEn=Zero. Next state FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next state FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next state FETCH.
- Defaults: every signal not listed for a state is 0.
- Cycle counts with mem_ready held at 1: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3. Each memory wait cycle adds 1.
- Opcode is sampled only in DECODE and MEMADR. IRWrite=0 in those states, so the value is stable.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams
  - state encodings
  - ALUOp, PCSrc and ALUSrcB codes
- These are shared with the ALU decoder and the testbench.
- No sub-module. The next-state logic and output decode are two always blocks in one module.

Test Plan:
- rst_n=0 for 2 cycles with mem_ready=1, then release -> state_dbg=0 and all write enables 0 during reset; the first post-reset cycle shows IRWrite=1, PCEn=1.
- Opcode=100011, mem_ready=1 -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
- Opcode=101011; mem_ready=0 for 3 cycles in MEMWR, then 1 -> MemWrite=1 for all 4 MEMWR cycles; return to FETCH after the 4th.
- Opcode=000100: Zero=1 gives PCEn=1 and PCSrc=01 in BRANCH; repeat with Zero=0 -> PCEn=0; both runs take 3 cycles.
- Opcode=111111 -> FETCH, DECODE, FETCH; illegal_op pulses for exactly 1 cycle; no write enables asserted.
- Assert rst_n=0 while in ALUWB -> RegWrite drops to 0 in that cycle; state_dbg=0 after the edge.
